// File: rtl/gpu_stream_reducer.sv
// gpu_stream_reducer: round-robin N-channel packet reducer feeding a tagged result FIFO
module gpu_stream_reducer #(
  parameter int N_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [N_CH-1:0]        src_vld,
  output logic [N_CH-1:0]        src_rdy,
  input  logic [N_CH*DATA_W-1:0] src_data,
  input  logic [N_CH-1:0]        src_last,
  output logic                   result_vld,
  input  logic                   result_rdy,
  output logic [DATA_W-1:0]      result_data,
  output logic [CH_W-1:0]        result_ch,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  logic [CH_W-1:0] ptr, gnt;
  logic gnt_vld, take, push, pop, first;
  logic [1:0] m;
  logic [DATA_W-1:0] d, base, red;
  logic [N_CH-1:0] inpkt, inpkt_nx;
  logic [DATA_W-1:0] acc [N_CH];
  logic [1:0] mode_q [N_CH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CH_W-1:0] mem_c [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt, cnt_nx;
  // first valid channel at or after ptr, wrapping; scanning downward lets the nearest one win
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (src_vld[(int'(ptr) + i) % N_CH]) begin
        gnt = CH_W'((int'(ptr) + i) % N_CH);
        gnt_vld = 1'b1;
      end
  end
  assign take = rst_n && gnt_vld && cnt != (AW+1)'(DEPTH);
  assign src_rdy = take ? N_CH'(1) << gnt : '0;
  assign d = src_data[int'(gnt)*DATA_W +: DATA_W];
  assign first = !inpkt[gnt];
  assign m = first ? mode : mode_q[gnt];
  assign base = first ? '0 : acc[gnt];
  assign red = m == 2'd0 ? base + d :
               m == 2'd1 ? (d > base ? d : base) :
               m == 2'd2 ? base ^ d : base + DATA_W'(1);
  assign push = take && src_last[gnt];
  assign pop = result_vld && result_rdy;
  assign cnt_nx = cnt + (AW+1)'(push) - (AW+1)'(pop);
  // in-packet flags after this cycle's accepted beat, shared by the flags and busy
  always_comb begin
    inpkt_nx = inpkt;
    if (take) inpkt_nx[gnt] = !src_last[gnt];
  end
  assign result_vld = cnt != '0;
  assign result_data = result_vld ? mem_d[rd] : '0;
  assign result_ch = result_vld ? mem_c[rd] : '0;
  // per-channel accumulators, latched modes and the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      inpkt <= '0;
      for (int c = 0; c < N_CH; c++) begin
        acc[c] <= '0;
        mode_q[c] <= '0;
      end
    end else begin
      inpkt <= inpkt_nx;
      if (take) begin
        acc[gnt] <= red;
        mode_q[gnt] <= m;
        ptr <= gnt == CH_W'(N_CH - 1) ? '0 : gnt + CH_W'(1);
      end
    end
  end
  // result FIFO storage, pointers, occupancy and the busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      busy <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        mem_d[e] <= '0;
        mem_c[e] <= '0;
      end
    end else begin
      cnt <= cnt_nx;
      busy <= |inpkt_nx || cnt_nx != '0;
      if (push) begin
        mem_d[wr] <= red;
        mem_c[wr] <= gnt;
        wr <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
    end
  end
endmodule
